// File: rtl/multi_byte_sub_add_ctrl.sv
// ---------------------------------------------------------------------------
// multi_byte_sub_add_ctrl
//
// Purpose:
//   Sequences an NBYTES-wide add or subtract through one external 8-bit
//   add/sub datapath (eight_bit_sub_add). It works least-significant byte
//   first, passes the carry/borrow from each byte to the next, and builds
//   the wide result in a register. A START/DONE handshake connects it to
//   the requesting unit.
//
// Parameters:
//   NBYTES      number of 8-bit slices per operand (>= 1); W = 8*NBYTES
//
// Ports:
//   CLK         system clock, all state changes on the rising edge
//   RST         synchronous, active-high reset
//   START       request strobe, only looked at while idle
//   OP          1 = subtract (X - Y), 0 = add (X + Y), captured with START
//   X, Y        W-bit operands, captured with START
//   BUSY        high while a request is in progress
//   DONE        one-cycle pulse, RESULT/COUT/OVF/ZERO valid
//   RESULT      assembled W-bit result
//   COUT        carry (add) / borrow (sub) out of the most significant byte
//   OVF         signed two's-complement overflow of the W-bit operation
//   ZERO        RESULT == 0
//   DP_A, DP_B  operand bytes to the datapath
//   DP_SUB_ADD  operation select to the datapath
//   DP_CIN      carry/borrow in to the datapath
//   DP_S        byte result from the datapath
//   DP_COUT     carry/borrow out from the datapath
// ---------------------------------------------------------------------------
module multi_byte_sub_add_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  OP,
  input  logic [8*NBYTES-1:0]   X,
  input  logic [8*NBYTES-1:0]   Y,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [8*NBYTES-1:0]   RESULT,
  output logic                  COUT,
  output logic                  OVF,
  output logic                  ZERO,
  output logic [7:0]            DP_A,
  output logic [7:0]            DP_B,
  output logic                  DP_SUB_ADD,
  output logic                  DP_CIN,
  input  logic [7:0]            DP_S,
  input  logic                  DP_COUT
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]    state_q,  state_d;
  logic [W-1:0]  opA_q,    opA_d;
  logic [W-1:0]  opB_q,    opB_d;
  logic          sub_q,    sub_d;
  logic [IW-1:0] idx_q,    idx_d;
  logic          carry_q,  carry_d;
  logic [W-1:0]  result_q, result_d;
  logic          cout_q,   cout_d;
  logic          ovf_q,    ovf_d;
  logic          zero_q,   zero_d;

  logic [7:0]    aByte;
  logic [7:0]    bByte;
  logic          signX;
  logic          signY;
  logic          signS;
  logic          ovfFinal;

  // Select the operand bytes for the current slice. A compare-per-slice mux
  // keeps every part-select constant, so no index ever falls out of range.
  always_comb begin
    aByte = 8'h00;
    bByte = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx_q == IW'(i)) begin
        aByte = opA_q[8*i +: 8];
        bByte = opB_q[8*i +: 8];
      end
    end
  end

  // Drive the datapath only while slices are processed. Outside RUN it sees
  // all zeros, so its output does not toggle when no operation is active.
  always_comb begin
    DP_A       = 8'h00;
    DP_B       = 8'h00;
    DP_SUB_ADD = 1'b0;
    DP_CIN     = 1'b0;
    if (state_q == RUN) begin
      DP_A       = aByte;
      DP_B       = bByte;
      DP_SUB_ADD = sub_q;
      DP_CIN     = carry_q;
    end
  end

  // Signed overflow looks at the sign of the final byte result produced by
  // the datapath. An add overflows when the operands share a sign and the
  // result does not. A subtract overflows when the operand signs differ and
  // the result sign moves away from X.
  always_comb begin
    signX = opA_q[W-1];
    signY = opB_q[W-1];
    signS = DP_S[7];
    if (sub_q) begin
      ovfFinal = (signX != signY) && (signS != signX);
    end else begin
      ovfFinal = (signX == signY) && (signS != signX);
    end
  end

  // Next-state logic for the sequencer. RESULT bytes are written one per
  // RUN cycle. Status flags (COUT/OVF/ZERO) are updated only on the step
  // into FIN, so their values stay stable between operations.
  always_comb begin
    state_d  = state_q;
    opA_d    = opA_q;
    opB_d    = opB_q;
    sub_d    = sub_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    case (state_q)
      IDLE: begin
        if (START) begin
          opA_d   = X;
          opB_d   = Y;
          sub_d   = OP;
          idx_d   = '0;
          carry_d = 1'b0;
          state_d = RUN;
        end
      end

      RUN: begin
        for (int i = 0; i < NBYTES; i++) begin
          if (idx_q == IW'(i)) begin
            result_d[8*i +: 8] = DP_S;
          end
        end
        carry_d = DP_COUT;
        if (idx_q == LAST_IDX) begin
          // ZERO must see the complete result, including the byte being
          // written on this edge, so it is taken from result_d.
          idx_d   = '0;
          cout_d  = DP_COUT;
          ovf_d   = ovfFinal;
          zero_d  = (result_d == '0);
          state_d = FIN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers. A reset also cancels a request in flight, and no DONE
  // is produced for it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      opA_q    <= '0;
      opB_q    <= '0;
      sub_q    <= 1'b0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      opA_q    <= opA_d;
      opB_q    <= opB_d;
      sub_q    <= sub_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  // Handshake and status outputs come straight from the registers.
  always_comb begin
    BUSY   = (state_q == RUN) || (state_q == FIN);
    DONE   = (state_q == FIN);
    RESULT = result_q;
    COUT   = cout_q;
    OVF    = ovf_q;
    ZERO   = zero_q;
  end

endmodule

// File: tb/tb_multi_byte_sub_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multi_byte_sub_add_ctrl
//
// Testbench for multi_byte_sub_add_ctrl with NBYTES = 4. It includes a
// behavioural model of the external 8-bit datapath, a fixed table of
// operations, random operations compared against a whole-word arithmetic
// reference, and hand-written sequences for held START, START while busy,
// and reset in the middle of an operation.
// ---------------------------------------------------------------------------
module tb_multi_byte_sub_add_ctrl;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic          CLK = 1'b0;
  logic          RST;
  logic          START;
  logic          OP;
  logic [W-1:0]  X;
  logic [W-1:0]  Y;
  logic          BUSY;
  logic          DONE;
  logic [W-1:0]  RESULT;
  logic          COUT;
  logic          OVF;
  logic          ZERO;
  logic [7:0]    DP_A;
  logic [7:0]    DP_B;
  logic          DP_SUB_ADD;
  logic          DP_CIN;
  logic [7:0]    DP_S;
  logic          DP_COUT;

  int passCount  = 0;
  int checkCount = 0;

  multi_byte_sub_add_ctrl #(.NBYTES(NB)) dut (
    .CLK(CLK), .RST(RST), .START(START), .OP(OP), .X(X), .Y(Y),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .COUT(COUT), .OVF(OVF),
    .ZERO(ZERO), .DP_A(DP_A), .DP_B(DP_B), .DP_SUB_ADD(DP_SUB_ADD),
    .DP_CIN(DP_CIN), .DP_S(DP_S), .DP_COUT(DP_COUT)
  );

  always #5 CLK = ~CLK;

  // Behavioural eight_bit_sub_add: 9-bit arithmetic. Bit 8 is the carry
  // for an add and the borrow for a subtract.
  always_comb begin
    logic [8:0] t;
    if (DP_SUB_ADD) t = {1'b0, DP_A} - {1'b0, DP_B} - {8'd0, DP_CIN};
    else            t = {1'b0, DP_A} + {1'b0, DP_B} + {8'd0, DP_CIN};
    DP_S    = t[7:0];
    DP_COUT = t[8];
  end

  typedef struct {
    logic         op;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
    logic         zero;
  } vec_t;

  task automatic checkOutput(input string name, input longint unsigned actual,
                             input longint unsigned expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Whole-word reference: plain wide arithmetic, no byte slicing.
  function automatic void refModel(input logic op, input logic [W-1:0] x, input logic [W-1:0] y,
                                   output logic [W-1:0] res, output logic cout,
                                   output logic ovf, output logic zero);
    longint unsigned ux = longint'(x);
    longint unsigned uy = longint'(y);
    longint sx = x[W-1] ? longint'(ux) - (longint'(1) << W) : longint'(ux);
    longint sy = y[W-1] ? longint'(uy) - (longint'(1) << W) : longint'(uy);
    longint sr = op ? sx - sy : sx + sy;
    longint unsigned ur = op ? ux - uy : ux + uy;
    res  = ur[W-1:0];
    cout = op ? (ux < uy) : ((ux + uy) >> W) != 0;
    ovf  = (sr > ((longint'(1) << (W-1)) - 1)) || (sr < -(longint'(1) << (W-1)));
    zero = (ur[W-1:0] == '0);
  endfunction

  // Carry/borrow that must enter byte i: derived from the low i bytes.
  function automatic logic carryInto(input logic op, input logic [W-1:0] x,
                                     input logic [W-1:0] y, input int i);
    longint unsigned m  = longint'(1) << (8*i);
    longint unsigned xl = longint'(x) % m;
    longint unsigned yl = longint'(y) % m;
    return op ? (xl < yl) : ((xl + yl) >= m);
  endfunction

  // Runs one request from IDLE and checks datapath drive on every cycle.
  // Returns the flags sampled while DONE is high, the DONE latency in
  // cycles after the accepting edge, and the carry-in seen by each byte.
  task automatic applyStimulus(input logic op, input logic [W-1:0] x, input logic [W-1:0] y,
                               output logic [W-1:0] gRes, output logic gCout,
                               output logic gOvf, output logic gZero,
                               output int latency, output logic [NB-1:0] cinSeq);
    latency = 0;
    cinSeq  = '0;
    @(negedge CLK);
    START = 1'b1; OP = op; X = x; Y = y;
    @(negedge CLK);
    START = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge CLK);
      if (DONE) begin
        latency = k;
        break;
      end
      if (k <= NB) begin
        cinSeq[k-1] = DP_CIN;
        checkOutput($sformatf("dpA[%0d]", k-1), DP_A, x[8*(k-1) +: 8]);
        checkOutput($sformatf("dpB[%0d]", k-1), DP_B, y[8*(k-1) +: 8]);
        checkOutput($sformatf("dpOp[%0d]", k-1), DP_SUB_ADD, op);
        checkOutput($sformatf("dpCin[%0d]", k-1), DP_CIN, carryInto(op, x, y, k-1));
        checkOutput("busyRun", BUSY, 1);
      end
    end
    checkOutput("doneLatency", latency, NB + 1);
    checkOutput("busyFin", BUSY, 1);
    checkOutput("dpIdleFin", {DP_A, DP_B, DP_SUB_ADD, DP_CIN}, 0);
    gRes = RESULT; gCout = COUT; gOvf = OVF; gZero = ZERO;
  endtask

  vec_t vecs[6];

  initial begin
    logic [W-1:0] gRes, eRes, hRes;
    logic gCout, gOvf, gZero, eCout, eOvf, eZero;
    int lat;
    logic [NB-1:0] cins;
    int doneCount, lastDone, gapErr, dpErr, wideDone, resErr, dones;
    logic prevDone;
    logic [7:0] aSeq[$];

    vecs[0] = '{1'b0, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 32'h00000005, 32'h00000002, 32'h00000003, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};

    RST = 1'b1; START = 1'b0; OP = 1'b0; X = '0; Y = '0;
    repeat (2) @(negedge CLK);
    checkOutput("rstBusy", BUSY, 0);
    checkOutput("rstDone", DONE, 0);
    checkOutput("rstResult", RESULT, 0);
    checkOutput("rstCout", COUT, 0);
    checkOutput("rstOvf", OVF, 0);
    checkOutput("rstZero", ZERO, 1);
    checkOutput("rstDp", {DP_A, DP_B, DP_SUB_ADD, DP_CIN}, 0);
    RST = 1'b0;

    // Directed table
    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].op, vecs[v].x, vecs[v].y, gRes, gCout, gOvf, gZero, lat, cins);
      checkOutput($sformatf("vec%0d.result", v), gRes, vecs[v].res);
      checkOutput($sformatf("vec%0d.cout", v), gCout, vecs[v].cout);
      checkOutput($sformatf("vec%0d.ovf", v), gOvf, vecs[v].ovf);
      checkOutput($sformatf("vec%0d.zero", v), gZero, vecs[v].zero);
      if (v == 0) checkOutput("vec0.cinSeq", cins, 4'b0010);
      @(negedge CLK);
      checkOutput($sformatf("vec%0d.holdIdle", v), {RESULT, BUSY, DONE}, {vecs[v].res, 2'b00});
    end

    // Random operations compared against the reference model
    for (int n = 0; n < 40; n++) begin
      logic o;
      logic [W-1:0] rx, ry;
      o  = 1'($urandom_range(0, 1));
      rx = $urandom;
      ry = $urandom;
      if (n % 8 == 0) ry = rx;
      if (n % 8 == 1) rx = {1'b0, {(W-1){1'b1}}};
      applyStimulus(o, rx, ry, gRes, gCout, gOvf, gZero, lat, cins);
      refModel(o, rx, ry, eRes, eCout, eOvf, eZero);
      checkOutput($sformatf("rnd%0d.result", n), gRes, eRes);
      checkOutput($sformatf("rnd%0d.flags", n), {gCout, gOvf, gZero}, {eCout, eOvf, eZero});
    end

    // START held high: one accept every NB+2 cycles
    @(negedge CLK);
    START = 1'b1; OP = 1'b0; X = 32'd200; Y = 32'd200;
    doneCount = 0; lastDone = 0; gapErr = 0; dpErr = 0; wideDone = 0; resErr = 0;
    prevDone = 1'b0;
    aSeq.delete();
    for (int c = 1; c <= 24; c++) begin
      @(negedge CLK);
      if (DONE) begin
        if (doneCount > 0 && (c - lastDone) != NB + 2) gapErr++;
        if (doneCount == 0 && c != NB + 1) gapErr++;
        if (RESULT != 32'h190) resErr++;
        if (prevDone) wideDone++;
        doneCount++;
        lastDone = c;
      end
      if (!BUSY || DONE) begin
        if ({DP_A, DP_B, DP_SUB_ADD, DP_CIN} != 0) dpErr++;
      end else begin
        aSeq.push_back(DP_A);
      end
      prevDone = DONE;
    end
    START = 1'b0;
    checkOutput("heldDoneCount", doneCount, 4);
    checkOutput("heldGapErr", gapErr, 0);
    checkOutput("heldWideDone", wideDone, 0);
    checkOutput("heldResultErr", resErr, 0);
    checkOutput("heldDpIdle", dpErr, 0);
    checkOutput("heldRunCycles", aSeq.size(), 16);
    for (int i = 0; i < aSeq.size(); i++)
      checkOutput($sformatf("heldDpA[%0d]", i), aSeq[i], (i % NB == 0) ? 8'hC8 : 8'h00);
    repeat (8) @(negedge CLK);

    // START pulsed during RUN is ignored
    START = 1'b1; OP = 1'b0; X = 32'd10; Y = 32'd20;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    START = 1'b1; OP = 1'b1; X = 32'd999; Y = 32'd1;
    @(negedge CLK);
    START = 1'b0;
    lat = 0;
    for (int k = 4; k <= 20; k++) begin
      @(negedge CLK);
      if (DONE) begin lat = k; break; end
    end
    checkOutput("ignLatency", lat, NB + 1);
    checkOutput("ignResult", RESULT, 32'd30);
    checkOutput("ignCout", COUT, 0);
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      if (BUSY) dones++;
    end
    checkOutput("ignNoQueue", dones, 0);

    // Reset during the second RUN cycle aborts the request
    START = 1'b1; OP = 1'b0; X = 32'h12345678; Y = 32'h11111111;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    checkOutput("abortBusy", BUSY, 0);
    checkOutput("abortDone", DONE, 0);
    checkOutput("abortResult", RESULT, 0);
    checkOutput("abortZero", ZERO, 1);
    checkOutput("abortFlags", {COUT, OVF}, 0);
    RST = 1'b0;
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      if (DONE || BUSY) dones++;
    end
    checkOutput("abortNoDone", dones, 0);
    applyStimulus(1'b0, 32'd10, 32'd2, hRes, gCout, gOvf, gZero, lat, cins);
    checkOutput("postAbortResult", hRes, 32'd12);
    checkOutput("postAbortFlags", {gCout, gOvf, gZero}, 3'b000);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
